// File: rtl/icache.sv
// Direct-mapped instruction cache with one 32-bit word per line.
// A hit responds on the next clock edge.
// A miss asks the memory controller for the word, fills the line,
// and sends the fill word straight on to fetch in the same cycle.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | ready for a fetch request; hits answered, misses launched
// MISS   | memory controller request outstanding; waiting for its ack
module icache #(
    parameter int ADDR_WIDTH  = 32,
    parameter int INSTR_WIDTH = 32,
    parameter int INDEX_WIDTH = 8
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   rdy_in,
    input  logic                   if_to_icache_en_in,
    input  logic [ADDR_WIDTH-1:0]  if_a_in,
    output logic                   icache_to_if_en_out,
    output logic [INSTR_WIDTH-1:0] if_d_out,
    output logic                   icache_to_mc_en_out,
    output logic [ADDR_WIDTH-1:0]  mc_a_out,
    input  logic                   mc_to_icache_en_in,
    input  logic [INSTR_WIDTH-1:0] mc_d_in,
    input  logic                   clear_branch_in
);

    localparam int LINES     = 1 << INDEX_WIDTH;
    localparam int TAG_WIDTH = ADDR_WIDTH - INDEX_WIDTH - 2;

    typedef enum logic {S_IDLE, S_MISS} state_t;

    state_t                   state_q, state_nxt;
    logic                     drop_q, drop_nxt;
    logic [INDEX_WIDTH-1:0]   miss_index_q, miss_index_nxt;
    logic [TAG_WIDTH-1:0]     miss_tag_q, miss_tag_nxt;
    logic                     resp_en_nxt;
    logic [INSTR_WIDTH-1:0]   resp_d_nxt;
    logic                     mc_en_nxt;
    logic [ADDR_WIDTH-1:0]    mc_a_nxt;
    logic                     fill_we;

    logic [LINES-1:0]         valid_q;
    logic [TAG_WIDTH-1:0]     tag_q  [LINES];
    logic [INSTR_WIDTH-1:0]   data_q [LINES];

    logic [INDEX_WIDTH-1:0]   req_index;
    logic [TAG_WIDTH-1:0]     req_tag;
    logic                     req_hit;
    logic                     unused_addr_bits;

    assign req_index        = if_a_in[INDEX_WIDTH+1:2];
    assign req_tag          = if_a_in[ADDR_WIDTH-1:INDEX_WIDTH+2];
    assign req_hit          = valid_q[req_index] && (tag_q[req_index] == req_tag);
    assign unused_addr_bits = ^if_a_in[1:0];

    // Next-state, next-output and fill-enable decode.
    always_comb begin
        state_nxt      = state_q;
        drop_nxt       = drop_q;
        miss_index_nxt = miss_index_q;
        miss_tag_nxt   = miss_tag_q;
        resp_en_nxt    = 1'b0;
        resp_d_nxt     = if_d_out;
        mc_en_nxt      = icache_to_mc_en_out;
        mc_a_nxt       = mc_a_out;
        fill_we        = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (if_to_icache_en_in && !clear_branch_in) begin
                    if (req_hit) begin
                        resp_en_nxt = 1'b1;
                        resp_d_nxt  = data_q[req_index];
                    end else begin
                        mc_en_nxt      = 1'b1;
                        mc_a_nxt       = {if_a_in[ADDR_WIDTH-1:2], 2'b00};
                        miss_index_nxt = req_index;
                        miss_tag_nxt   = req_tag;
                        state_nxt      = S_MISS;
                    end
                end
            end
            S_MISS: begin
                // The memory controller cannot abort, so a flush only
                // suppresses the eventual response to fetch.
                if (clear_branch_in) drop_nxt = 1'b1;
                if (mc_to_icache_en_in) begin
                    fill_we   = 1'b1;
                    mc_en_nxt = 1'b0;
                    drop_nxt  = 1'b0;
                    state_nxt = S_IDLE;
                    if (!drop_q && !clear_branch_in) begin
                        resp_en_nxt = 1'b1;
                        resp_d_nxt  = mc_d_in;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Control state and registered outputs; frozen while rdy_in is low.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q             <= S_IDLE;
            drop_q              <= 1'b0;
            miss_index_q        <= '0;
            miss_tag_q          <= '0;
            icache_to_if_en_out <= 1'b0;
            if_d_out            <= '0;
            icache_to_mc_en_out <= 1'b0;
            mc_a_out            <= '0;
        end else if (rdy_in) begin
            state_q             <= state_nxt;
            drop_q              <= drop_nxt;
            miss_index_q        <= miss_index_nxt;
            miss_tag_q          <= miss_tag_nxt;
            icache_to_if_en_out <= resp_en_nxt;
            if_d_out            <= resp_d_nxt;
            icache_to_mc_en_out <= mc_en_nxt;
            mc_a_out            <= mc_a_nxt;
        end
    end

    // Valid bits are the only part of the array that needs a reset.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            valid_q <= '0;
        end else if (rdy_in && fill_we) begin
            valid_q[miss_index_q] <= 1'b1;
        end
    end

    // Tag and data storage, written only on a fill.
    always_ff @(posedge clk_in) begin
        if (rdy_in && fill_we) begin
            tag_q[miss_index_q]  <= miss_tag_q;
            data_q[miss_index_q] <= mc_d_in;
        end
    end

endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: cold miss, hit, conflict, flush, stall, async reset.
module tb_icache;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        if_to_icache_en_in;
    logic [31:0] if_a_in;
    logic        icache_to_if_en_out;
    logic [31:0] if_d_out;
    logic        icache_to_mc_en_out;
    logic [31:0] mc_a_out;
    logic        mc_to_icache_en_in;
    logic [31:0] mc_d_in;
    logic        clear_branch_in;

    int checks   = 0;
    int failures = 0;

    icache dut (
        .clk_in              (clk_in),
        .rst_in              (rst_in),
        .rdy_in              (rdy_in),
        .if_to_icache_en_in  (if_to_icache_en_in),
        .if_a_in             (if_a_in),
        .icache_to_if_en_out (icache_to_if_en_out),
        .if_d_out            (if_d_out),
        .icache_to_mc_en_out (icache_to_mc_en_out),
        .mc_a_out            (mc_a_out),
        .mc_to_icache_en_in  (mc_to_icache_en_in),
        .mc_d_in             (mc_d_in),
        .clear_branch_in     (clear_branch_in)
    );

    always #5 clk_in = ~clk_in;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs driven afterwards land safely before the next edge.
    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle_inputs();
        if_to_icache_en_in = 1'b0;
        mc_to_icache_en_in = 1'b0;
        clear_branch_in    = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] a);
        if_to_icache_en_in = 1'b1;
        if_a_in            = a;
        tick();
        if_to_icache_en_in = 1'b0;
    endtask

    task automatic ack(input logic [31:0] d);
        mc_to_icache_en_in = 1'b1;
        mc_d_in            = d;
        tick();
        mc_to_icache_en_in = 1'b0;
    endtask

    initial begin
        rst_in = 1'b0;
        rdy_in = 1'b1;
        if_a_in = '0;
        mc_d_in = '0;
        idle_inputs();
        #12;
        check_eq("rst_if_en", {31'b0, icache_to_if_en_out}, 32'd0);
        check_eq("rst_if_d",  if_d_out, 32'd0);
        check_eq("rst_mc_en", {31'b0, icache_to_mc_en_out}, 32'd0);
        check_eq("rst_mc_a",  mc_a_out, 32'd0);
        rst_in = 1'b1;
        tick();

        // 1: cold miss, ack in the 4th cycle after the request
        fetch(32'h0000_0010);
        check_eq("t1_mc_en",  {31'b0, icache_to_mc_en_out}, 32'd1);
        check_eq("t1_mc_a",   mc_a_out, 32'h10);
        check_eq("t1_if_en0", {31'b0, icache_to_if_en_out}, 32'd0);
        tick();
        tick();
        check_eq("t1_mc_hold", {31'b0, icache_to_mc_en_out}, 32'd1);
        ack(32'hDEAD_BEEF);
        check_eq("t1_if_en",  {31'b0, icache_to_if_en_out}, 32'd1);
        check_eq("t1_if_d",   if_d_out, 32'hDEAD_BEEF);
        check_eq("t1_mc_drop", {31'b0, icache_to_mc_en_out}, 32'd0);
        tick();
        check_eq("t1_if_en_pulse", {31'b0, icache_to_if_en_out}, 32'd0);

        // 2: hit
        fetch(32'h0000_0010);
        check_eq("t2_if_en", {31'b0, icache_to_if_en_out}, 32'd1);
        check_eq("t2_if_d",  if_d_out, 32'hDEAD_BEEF);
        check_eq("t2_mc_en", {31'b0, icache_to_mc_en_out}, 32'd0);

        // 3: conflict on index 4, then original address misses again
        fetch(32'h0000_0412);
        check_eq("t3_mc_en", {31'b0, icache_to_mc_en_out}, 32'd1);
        check_eq("t3_mc_a",  mc_a_out, 32'h410);
        check_eq("t3_if_en0", {31'b0, icache_to_if_en_out}, 32'd0);
        tick();
        ack(32'h1234_5678);
        check_eq("t3_if_en", {31'b0, icache_to_if_en_out}, 32'd1);
        check_eq("t3_if_d",  if_d_out, 32'h1234_5678);
        fetch(32'h0000_0410);
        check_eq("t3_hit_new", if_d_out, 32'h1234_5678);
        check_eq("t3_hit_new_mc", {31'b0, icache_to_mc_en_out}, 32'd0);
        fetch(32'h0000_0010);
        check_eq("t3_remiss", {31'b0, icache_to_mc_en_out}, 32'd1);
        check_eq("t3_remiss_a", mc_a_out, 32'h10);
        ack(32'hDEAD_BEEF);
        check_eq("t3_refill", if_d_out, 32'hDEAD_BEEF);

        // 4: flush mid-miss, with a fetch attempt ignored while waiting
        fetch(32'h0000_0020);
        check_eq("t4_mc_en", {31'b0, icache_to_mc_en_out}, 32'd1);
        tick();
        clear_branch_in = 1'b1;
        tick();
        clear_branch_in = 1'b0;
        check_eq("t4_mc_held", {31'b0, icache_to_mc_en_out}, 32'd1);
        fetch(32'h0000_0040);
        check_eq("t4_ignored_a", mc_a_out, 32'h20);
        ack(32'hCAFE_F00D);
        check_eq("t4_no_resp", {31'b0, icache_to_if_en_out}, 32'd0);
        check_eq("t4_mc_drop", {31'b0, icache_to_mc_en_out}, 32'd0);
        fetch(32'h0000_0020);
        check_eq("t4_hit_en", {31'b0, icache_to_if_en_out}, 32'd1);
        check_eq("t4_hit_d",  if_d_out, 32'hCAFE_F00D);

        // 5: stall for 4 cycles right after a hit response, request held
        rdy_in = 1'b0;
        if_to_icache_en_in = 1'b1;
        if_a_in = 32'h0000_0010;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq("t5_frozen_en", {31'b0, icache_to_if_en_out}, 32'd1);
            check_eq("t5_frozen_d",  if_d_out, 32'hCAFE_F00D);
        end
        rdy_in = 1'b1;
        tick();
        if_to_icache_en_in = 1'b0;
        check_eq("t5_resume_en", {31'b0, icache_to_if_en_out}, 32'd1);
        check_eq("t5_resume_d",  if_d_out, 32'hDEAD_BEEF);

        // IDLE flush discards a same-cycle request
        clear_branch_in = 1'b1;
        fetch(32'h0000_0010);
        clear_branch_in = 1'b0;
        check_eq("idle_clr_en", {31'b0, icache_to_if_en_out}, 32'd0);
        check_eq("idle_clr_mc", {31'b0, icache_to_mc_en_out}, 32'd0);

        // 6: async reset between edges during a miss
        fetch(32'h0000_0030);
        check_eq("t6_mc_en", {31'b0, icache_to_mc_en_out}, 32'd1);
        #2;
        rst_in = 1'b0;
        #1;
        check_eq("t6_rst_mc_en", {31'b0, icache_to_mc_en_out}, 32'd0);
        check_eq("t6_rst_mc_a",  mc_a_out, 32'd0);
        check_eq("t6_rst_if_d",  if_d_out, 32'd0);
        @(negedge clk_in);
        rst_in = 1'b1;
        tick();
        fetch(32'h0000_0010);
        check_eq("t6_cold_en", {31'b0, icache_to_mc_en_out}, 32'd1);
        check_eq("t6_cold_if", {31'b0, icache_to_if_en_out}, 32'd0);
        ack(32'h0BAD_F00D);
        check_eq("t6_fill_d", if_d_out, 32'h0BAD_F00D);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
